// File: rtl/tv80_bus_bridge.sv
// tv80s bus bridge: turns Z80 bus strobes into one req/ack transaction per CPU bus cycle.
// Optional REQ timeout with sticky bus_err: define TV80_BRIDGE_TIMEOUT_EN.
module tv80_bus_bridge #(
    parameter logic [7:0]  INTA_VECTOR = 8'hFF,
    parameter int unsigned TIMEOUT     = 16
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [15:0] cpu_a,
    input  logic [7:0]  cpu_do,
    output logic [7:0]  cpu_di,
    input  logic        cpu_mreq_n,
    input  logic        cpu_iorq_n,
    input  logic        cpu_rd_n,
    input  logic        cpu_wr_n,
    input  logic        cpu_m1_n,
    input  logic        cpu_rfsh_n,
    output logic        cpu_wait_n,
    output logic        mem_req,
    output logic        mem_we,
    output logic        mem_io,
    output logic [15:0] mem_addr,
    output logic [7:0]  mem_wdata,
    input  logic [7:0]  mem_rdata,
    input  logic        mem_ack,
    output logic        bus_err
);

    typedef enum logic [1:0] {IDLE, REQ, DONE} state_t;

    state_t      state_q, state_d;
    logic [7:0]  cpu_di_q, cpu_di_d;
    logic        mem_req_q, mem_req_d;
    logic        mem_we_q, mem_we_d;
    logic        mem_io_q, mem_io_d;
    logic [15:0] mem_addr_q, mem_addr_d;
    logic [7:0]  mem_wdata_q, mem_wdata_d;
    logic        start, inta, bus_released, timeout_hit;

    assign start        = ((~cpu_mreq_n & cpu_rfsh_n) | (~cpu_iorq_n & cpu_m1_n)) & (~cpu_rd_n | ~cpu_wr_n);
    assign inta         = ~cpu_iorq_n & ~cpu_m1_n;
    assign bus_released = (cpu_mreq_n & cpu_iorq_n) | (cpu_rd_n & cpu_wr_n);

`ifdef TV80_BRIDGE_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT + 1);
    logic [CW-1:0] cnt_q, cnt_d;
    logic          bus_err_q, bus_err_d;
    assign timeout_hit = (cnt_q == CW'(TIMEOUT - 1));
    assign bus_err     = bus_err_q;
`else
    assign timeout_hit = 1'b0;
    assign bus_err     = 1'b0;
`endif

    always_comb begin
        state_d     = state_q;
        cpu_di_d    = cpu_di_q;
        mem_req_d   = mem_req_q;
        mem_we_d    = mem_we_q;
        mem_io_d    = mem_io_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
`ifdef TV80_BRIDGE_TIMEOUT_EN
        cnt_d       = cnt_q;
        bus_err_d   = bus_err_q;
`endif
        case (state_q)
            IDLE: begin
                // inta wins if both ever appear together
                if (inta) begin
                    state_d  = DONE;
                    cpu_di_d = INTA_VECTOR;
                end else if (start) begin
                    state_d     = REQ;
                    mem_req_d   = 1'b1;
                    mem_we_d    = ~cpu_wr_n;
                    mem_io_d    = ~cpu_iorq_n;
                    mem_addr_d  = cpu_a;
                    mem_wdata_d = cpu_do;
`ifdef TV80_BRIDGE_TIMEOUT_EN
                    cnt_d       = '0;
`endif
                end
            end
            REQ: begin
                if (mem_ack) begin
                    state_d   = DONE;
                    mem_req_d = 1'b0;
                    if (!mem_we_q) cpu_di_d = mem_rdata;
                end else if (timeout_hit) begin
                    state_d   = DONE;
                    mem_req_d = 1'b0;
                    cpu_di_d  = 8'hFF;
`ifdef TV80_BRIDGE_TIMEOUT_EN
                    bus_err_d = 1'b1;
                end else begin
                    cnt_d     = cnt_q + 1'b1;
`endif
                end
            end
            DONE: begin
                // wait for the CPU to end its bus cycle so each cycle yields one transaction
                if (bus_released) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= IDLE;
            cpu_di_q    <= 8'h00;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_io_q    <= 1'b0;
            mem_addr_q  <= 16'h0000;
            mem_wdata_q <= 8'h00;
`ifdef TV80_BRIDGE_TIMEOUT_EN
            cnt_q       <= '0;
            bus_err_q   <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            cpu_di_q    <= cpu_di_d;
            mem_req_q   <= mem_req_d;
            mem_we_q    <= mem_we_d;
            mem_io_q    <= mem_io_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
`ifdef TV80_BRIDGE_TIMEOUT_EN
            cnt_q       <= cnt_d;
            bus_err_q   <= bus_err_d;
`endif
        end
    end

    // Gated by reset_n so the CPU is released the moment reset asserts.
    assign cpu_wait_n = ~(reset_n & (((state_q == IDLE) & start) | (state_q == REQ)));
    assign cpu_di     = cpu_di_q;
    assign mem_req    = mem_req_q;
    assign mem_we     = mem_we_q;
    assign mem_io     = mem_io_q;
    assign mem_addr   = mem_addr_q;
    assign mem_wdata  = mem_wdata_q;

endmodule

// File: tb/tb_tv80_bus_bridge.sv
// Bench for tv80_bus_bridge: directed scenarios plus random CPU bus cycles against a
// transaction-level model (memory array, expected cpu_di, expected wait/req cycle counts).
module tb_tv80_bus_bridge;
    localparam int         TB_TIMEOUT = 16;
    localparam logic [7:0] TB_INTA    = 8'hFF;

    logic        clk, reset_n;
    logic [15:0] cpu_a;
    logic [7:0]  cpu_do, cpu_di;
    logic        cpu_mreq_n, cpu_iorq_n, cpu_rd_n, cpu_wr_n, cpu_m1_n, cpu_rfsh_n, cpu_wait_n;
    logic        mem_req, mem_we, mem_io, mem_ack, bus_err;
    logic [15:0] mem_addr;
    logic [7:0]  mem_wdata, mem_rdata;

    int          total = 0;
    int          bad = 0;
    logic [7:0]  exp_di = 8'h00;
    logic        exp_err = 1'b0;
    logic [7:0]  mem_model [int];

    tv80_bus_bridge #(.INTA_VECTOR(TB_INTA), .TIMEOUT(TB_TIMEOUT)) dut (
        .clk(clk), .reset_n(reset_n), .cpu_a(cpu_a), .cpu_do(cpu_do), .cpu_di(cpu_di),
        .cpu_mreq_n(cpu_mreq_n), .cpu_iorq_n(cpu_iorq_n), .cpu_rd_n(cpu_rd_n), .cpu_wr_n(cpu_wr_n),
        .cpu_m1_n(cpu_m1_n), .cpu_rfsh_n(cpu_rfsh_n), .cpu_wait_n(cpu_wait_n),
        .mem_req(mem_req), .mem_we(mem_we), .mem_io(mem_io), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ack(mem_ack), .bus_err(bus_err)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic bus_idle();
        cpu_mreq_n = 1'b1; cpu_iorq_n = 1'b1; cpu_rd_n = 1'b1; cpu_wr_n = 1'b1;
        cpu_m1_n = 1'b1; cpu_rfsh_n = 1'b1;
    endtask

    // One CPU bus cycle. ack_delay = REQ cycle in which the target acks; 0 = never ack.
    task automatic run_txn(input bit is_io, input bit is_wr, input logic [15:0] addr,
                           input logic [7:0] wdata, input int ack_delay, input logic [7:0] io_rdata,
                           input int hold_extra, input string name);
        logic [7:0] rd;
        int req_cycles, wait_low, rises, exp_req;
        bit prev, done;
        rd = is_io ? io_rdata : (mem_model.exists(addr) ? mem_model[addr] : 8'h00);
        exp_req = (ack_delay == 0) ? TB_TIMEOUT : ack_delay;
        @(negedge clk);
        cpu_a = addr; cpu_do = wdata;
        if (is_io) cpu_iorq_n = 1'b0; else cpu_mreq_n = 1'b0;
        if (is_wr) cpu_wr_n = 1'b0; else cpu_rd_n = 1'b0;
        #1;
        total++;
        if (cpu_wait_n !== 1'b0) begin bad++; $display("FAIL %s wait_on_start got=%b want=0", name, cpu_wait_n); end
        req_cycles = 0; wait_low = 0; rises = 0; prev = 1'b0; done = 1'b0;
        for (int c = 0; c < 64 && !done; c++) begin
            @(posedge clk); #1;
            mem_ack = 1'b0;
            if (!cpu_wait_n) wait_low++;
            if (mem_req && !prev) rises++;
            prev = mem_req;
            if (mem_req) begin
                req_cycles++;
                if (req_cycles == ack_delay) begin mem_ack = 1'b1; mem_rdata = rd; end
            end else begin
                done = 1'b1;
            end
        end
        mem_ack = 1'b0;
        total++;
        if (!done) begin bad++; $display("FAIL %s no_completion got=pending want=done", name); end
        if (ack_delay == 0) begin exp_di = 8'hFF; exp_err = 1'b1; end
        else if (!is_wr) exp_di = rd;
        if (is_wr && !is_io) mem_model[addr] = wdata;
        total += 9;
        if (req_cycles !== exp_req) begin bad++; $display("FAIL %s req_cycles got=%0d want=%0d", name, req_cycles, exp_req); end
        if (wait_low !== exp_req) begin bad++; $display("FAIL %s wait_cycles got=%0d want=%0d", name, wait_low, exp_req); end
        if (rises !== 1) begin bad++; $display("FAIL %s req_pulses got=%0d want=1", name, rises); end
        if (cpu_di !== exp_di) begin bad++; $display("FAIL %s cpu_di got=%h want=%h", name, cpu_di, exp_di); end
        if (cpu_wait_n !== 1'b1) begin bad++; $display("FAIL %s wait_done got=%b want=1", name, cpu_wait_n); end
        if (bus_err !== exp_err) begin bad++; $display("FAIL %s bus_err got=%b want=%b", name, bus_err, exp_err); end
        if (mem_addr !== addr) begin bad++; $display("FAIL %s mem_addr got=%h want=%h", name, mem_addr, addr); end
        if (mem_we !== is_wr) begin bad++; $display("FAIL %s mem_we got=%b want=%b", name, mem_we, is_wr); end
        if (mem_io !== is_io) begin bad++; $display("FAIL %s mem_io got=%b want=%b", name, mem_io, is_io); end
        if (is_wr) begin
            total++;
            if (mem_wdata !== wdata) begin bad++; $display("FAIL %s mem_wdata got=%h want=%h", name, mem_wdata, wdata); end
        end
        for (int h = 0; h < hold_extra; h++) begin
            @(posedge clk); #1;
            total++;
            if (mem_req !== 1'b0 || cpu_wait_n !== 1'b1) begin
                bad++; $display("FAIL %s hold_req_wait got=%b%b want=01", name, mem_req, cpu_wait_n);
            end
        end
        @(negedge clk); bus_idle();
        @(posedge clk); #1;
        $display("txn %s io=%0b wr=%0b addr=%h req_cycles=%0d cpu_di=%h", name, is_io, is_wr, addr, req_cycles, cpu_di);
    endtask

    task automatic test_reset();
        total += 8;
        if (cpu_di !== 8'h00) begin bad++; $display("FAIL reset cpu_di got=%h want=00", cpu_di); end
        if (mem_req !== 1'b0) begin bad++; $display("FAIL reset mem_req got=%b want=0", mem_req); end
        if (mem_we !== 1'b0) begin bad++; $display("FAIL reset mem_we got=%b want=0", mem_we); end
        if (mem_io !== 1'b0) begin bad++; $display("FAIL reset mem_io got=%b want=0", mem_io); end
        if (mem_addr !== 16'h0) begin bad++; $display("FAIL reset mem_addr got=%h want=0000", mem_addr); end
        if (mem_wdata !== 8'h00) begin bad++; $display("FAIL reset mem_wdata got=%h want=00", mem_wdata); end
        if (bus_err !== 1'b0) begin bad++; $display("FAIL reset bus_err got=%b want=0", bus_err); end
        cpu_mreq_n = 1'b0; cpu_rd_n = 1'b0; #1;
        if (cpu_wait_n !== 1'b1) begin bad++; $display("FAIL reset wait_n got=%b want=1", cpu_wait_n); end
        bus_idle();
        @(negedge clk); reset_n = 1'b1;
        @(posedge clk); #1;
        $display("txn reset released");
    endtask

    task automatic test_refresh();
        @(negedge clk);
        cpu_a = 16'($urandom); cpu_mreq_n = 1'b0; cpu_rfsh_n = 1'b0; cpu_rd_n = 1'b0;
        #1;
        total++;
        if (cpu_wait_n !== 1'b1) begin bad++; $display("FAIL refresh wait_now got=%b want=1", cpu_wait_n); end
        for (int c = 0; c < 3; c++) begin
            @(posedge clk); #1;
            total++;
            if (mem_req !== 1'b0 || cpu_wait_n !== 1'b1) begin
                bad++; $display("FAIL refresh req_wait got=%b%b want=01", mem_req, cpu_wait_n);
            end
        end
        @(negedge clk); bus_idle();
        @(posedge clk); #1;
        $display("txn refresh addr=%h", cpu_a);
    endtask

    task automatic test_inta();
        @(negedge clk);
        cpu_iorq_n = 1'b0; cpu_m1_n = 1'b0;
        for (int c = 0; c < 3; c++) begin
            @(posedge clk); #1;
            total++;
            if (mem_req !== 1'b0 || cpu_wait_n !== 1'b1) begin
                bad++; $display("FAIL inta req_wait got=%b%b want=01", mem_req, cpu_wait_n);
            end
        end
        exp_di = TB_INTA;
        total++;
        if (cpu_di !== exp_di) begin bad++; $display("FAIL inta cpu_di got=%h want=%h", cpu_di, exp_di); end
        @(negedge clk); bus_idle();
        @(posedge clk); #1;
        $display("txn inta cpu_di=%h", cpu_di);
    endtask

    task automatic test_stray_ack();
        @(negedge clk);
        mem_ack = 1'b1; mem_rdata = 8'($urandom) ^ exp_di ^ 8'h5A;
        @(posedge clk); #1;
        mem_ack = 1'b0;
        total++;
        if (mem_req !== 1'b0 || cpu_di !== exp_di) begin
            bad++; $display("FAIL stray_ack req_di got=%b/%h want=0/%h", mem_req, cpu_di, exp_di);
        end
        $display("txn stray_ack cpu_di=%h", cpu_di);
    endtask

    task automatic test_reset_mid();
        @(negedge clk);
        cpu_a = 16'h1234; cpu_mreq_n = 1'b0; cpu_rd_n = 1'b0;
        @(posedge clk); #1;
        total++;
        if (mem_req !== 1'b1) begin bad++; $display("FAIL reset_mid req_before got=%b want=1", mem_req); end
        reset_n = 1'b0; exp_di = 8'h00; exp_err = 1'b0;
        #1;
        total += 3;
        if (mem_req !== 1'b0) begin bad++; $display("FAIL reset_mid mem_req got=%b want=0", mem_req); end
        if (cpu_wait_n !== 1'b1) begin bad++; $display("FAIL reset_mid wait_n got=%b want=1", cpu_wait_n); end
        if (mem_addr !== 16'h0) begin bad++; $display("FAIL reset_mid mem_addr got=%h want=0000", mem_addr); end
        @(negedge clk); bus_idle();
        @(negedge clk); reset_n = 1'b1;
        @(posedge clk); #1;
        $display("txn reset_mid");
        run_txn(1'b0, 1'b0, 16'h5E1C, 8'h00, 2, 8'h00, 0, "after_reset_read");
    endtask

    task automatic test_random();
        for (int i = 0; i < 30; i++) begin
            int kind;
            logic [15:0] a;
            kind = int'($urandom_range(0, 5));
            a = {8'h40, 5'h00, 3'($urandom_range(0, 7))};
            case (kind)
                0: run_txn(1'b0, 1'b0, a, 8'h00, int'($urandom_range(1, 5)), 8'h00, int'($urandom_range(0, 2)), "rand_mem_rd");
                1: run_txn(1'b0, 1'b1, a, 8'($urandom), int'($urandom_range(1, 5)), 8'h00, int'($urandom_range(0, 2)), "rand_mem_wr");
                2: run_txn(1'b1, 1'b0, 16'($urandom), 8'h00, int'($urandom_range(1, 5)), 8'($urandom), int'($urandom_range(0, 2)), "rand_io_rd");
                3: run_txn(1'b1, 1'b1, 16'($urandom), 8'($urandom), int'($urandom_range(1, 5)), 8'h00, int'($urandom_range(0, 2)), "rand_io_wr");
                4: test_refresh();
                default: test_inta();
            endcase
        end
    endtask

`ifdef TV80_BRIDGE_TIMEOUT_EN
    task automatic test_timeout();
        run_txn(1'b0, 1'b0, 16'h7000, 8'h00, 0, 8'h00, 0, "timeout");
        run_txn(1'b0, 1'b0, 16'h5E1C, 8'h00, 1, 8'h00, 0, "after_timeout");
    endtask
`endif

    initial begin
        reset_n = 1'b0; mem_ack = 1'b0; mem_rdata = 8'h00; cpu_a = 16'h0; cpu_do = 8'h00;
        bus_idle();
        #12;
        test_reset();
        mem_model[16'h5E1C] = 8'h37;
        run_txn(1'b0, 1'b0, 16'h5E1C, 8'h00, 1, 8'h00, 0, "mem_read");
        run_txn(1'b0, 1'b1, 16'h4000, 8'hA1, 3, 8'h00, 0, "mem_write");
        run_txn(1'b1, 1'b0, 16'h5510, 8'h00, 2, 8'hC3, 0, "io_read");
        run_txn(1'b0, 1'b0, 16'h4000, 8'h00, 1, 8'h00, 3, "back_to_back_hold");
        test_refresh();
        test_inta();
        test_stray_ack();
        test_reset_mid();
`ifdef TV80_BRIDGE_TIMEOUT_EN
        test_timeout();
`endif
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
